cpu_run_sequencer: RTL
======================

# cpu_run_sequencer

Top-level sequencer for the 16-bit accumulator CPU and its single-port 13-bit-address program/data RAM. It owns the RAM port and the CPU reset. It loads a program image from an external word stream, then releases the CPU and lets it run. It detects completion (PC stuck in a self-jump) or a cycle-budget timeout, and reports the cycle count.

## Interface
- `HALT_WINDOW`, default 16: consecutive cycles of unchanged `cpu_PC` that define a halt. Must be ≥ 8; the longest instruction is 6 cycles.
- `MAX_CYCLES`, default 100000: RUN-state cycle budget before timeout.
- `CNT_W`, default 32: width of the cycle counter.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, asynchronous and active-low. Asserted when 0.
- `start`  in  1  one-cycle pulse. Accepted only in IDLE, HALTED or TIMEOUT.
- `ld_valid`  in  1  loader word valid.
- `ld_ready`  out  1  loader may present a word.
- `ld_addr`  in  13  RAM address of the loader word.
- `ld_data`  in  16  loader word.
- `ld_last`  in  1  marks the final word of the image.
- `cpu_rst`  out  1  active-high synchronous reset driven to the CPU `rst` input.
- `cpu_addr`  in  13  CPU `addr_toRAM`.
- `cpu_wrEn`  in  1  CPU `wrEn`.
- `cpu_wdata`  in  16  CPU `data_toRAM`.
- `cpu_PC`  in  13  CPU `PC`.
- `ram_addr`  out  13  RAM address.
- `ram_wrEn`  out  1  RAM write enable.
- `ram_wdata`  out  16  RAM write data.
- `ram_rdata`  in  16  RAM read data. Valid the cycle after its address. The CPU's `data_fromRAM` is wired directly from this signal.
- `busy`  out  1  high in LOAD or RUN.
- `done`  out  1  high in HALTED.
- `timeout`  out  1  high in TIMEOUT.
- `cycles`  out  `CNT_W`  RUN cycle count, held after RUN ends.

## Operation
State machine with states IDLE, LOAD, RUN, HALTED and TIMEOUT. The reset state is IDLE.

Transitions:
- IDLE, HALTED or TIMEOUT, on `start` → LOAD. On entry, `cycles` clears to 0.
- LOAD, on an accepted word with `ld_last` = 1 → RUN.
- RUN, when `cpu_PC` has been unchanged for `HALT_WINDOW` consecutive cycles → HALTED.
- RUN, when `cycles` reaches `MAX_CYCLES` → TIMEOUT. If both conditions occur in the same cycle, HALTED wins.

RAM port ownership (combinational mux, registered selector):
- LOAD: loader owns the port. `ram_addr` = `ld_addr`, `ram_wdata` = `ld_data`, `ram_wrEn` = `ld_valid & ld_ready`.
- RUN: CPU owns the port. `ram_*` pass through `cpu_*`.
- IDLE, HALTED and TIMEOUT: `ram_wrEn` = 0 and `ram_addr` = 0, unless the dump port is active (see Configuration).

Other rules:
- `ld_ready` = 1 only in LOAD. A word is accepted when `ld_valid & ld_ready`. Loader words may arrive in any address order. Repeated addresses are allowed; the last write wins.
- `cpu_rst` = 1 in every state except RUN. On entering RUN it deasserts the cycle after the `ld_last` word is written, so the CPU begins fetching at PC 0.
- Halt detection: register the previous `cpu_PC` and a stall counter. Any change in PC resets the counter. The counter is cleared on RUN entry and is meaningful only in RUN.
- `cycles` increments once per RUN cycle and saturates at all-ones.
- `start` received in LOAD or RUN is ignored.
- Reset asserted mid-LOAD or mid-RUN forces IDLE immediately. It also asserts `cpu_rst` and forces `ram_wrEn` to 0 immediately, with no partial write. RAM contents are not cleared.

## Timing
- Reset values: `ld_ready` 0, `cpu_rst` 1, `ram_wrEn` 0, `ram_addr` 0, `ram_wdata` 0, `busy` 0, `done` 0, `timeout` 0, `cycles` 0.
- The `ram_*` outputs are combinational from the state and the active owner's inputs. There is no added latency on the CPU path, which preserves the CPU's single-cycle read turnaround.
- LOAD throughput: one word per cycle.
- RUN → HALTED latency: `HALT_WINDOW` cycles after the last PC change. `cycles` includes these window cycles.
- `done` and `timeout` are registered, and rise in the first cycle of the corresponding state.

## Configuration
- `CPU_SEQ_DUMP_EN` defined adds a memory read-back port:
  - `dump_req` in 1 and `dump_addr` in 13.
  - `dump_valid` out 1 and `dump_data` out 16.
  - Honoured only in HALTED or TIMEOUT. `ram_addr` = `dump_addr`. One cycle later, `dump_valid` = 1 and `dump_data` = `ram_rdata`.
  - Requests in other states are ignored.
- `CPU_SEQ_DUMP_EN` undefined: these ports do not exist, and the RAM port idles in the non-RUN states.

## Structure
- Shared package `cpu_seq_pkg`: the state enum, the RAM address width (13), the data width (16), and the CPU opcode constants (ADD, NAND, SRL, GE, SZ, CP2W, CPfW, JMP) for bench reuse.
- One sub-module, `pc_halt_detect`. It contains the PC history register and stall counter, and outputs a halt pulse.

## Test plan
- Reset mid-LOAD: drop `rst` after 3 words. Required: IDLE, `cpu_rst` = 1, `ram_wrEn` = 0 in the same cycle, `ld_ready` = 0.
- Basic run: load `{0: CP2W 10, 1: ADD 11, 2: CPfW 12, 3: JMP 13, 10: 5, 11: 7, 13: 3}`, then `start`. Required: `done` = 1, RAM[12] = 12, `cycles` = measured RUN cycles (≥ 19 + `HALT_WINDOW`).
- Timeout: `MAX_CYCLES` = 50 with a program that loops over two PCs. Required: `timeout` = 1, `done` = 0, `cycles` = 50.
- Loader backpressure: `ld_valid` toggled 1/0 for 8 words. Required: exactly 8 RAM writes; RUN entered the cycle after the `ld_last` handshake.
- Restart: after HALTED, pulse `start` and reload. Required: `cycles` clears, the second run completes, and `start` during RUN has no effect.
- Dump (`CPU_SEQ_DUMP_EN`): after HALTED, `dump_req` with `dump_addr` = 12. Required: `dump_valid` = 1 with `dump_data` = 12 one cycle later.

Source files
------------

// File: rtl/cpu_seq_pkg.sv
// Shared definitions for the CPU run sequencer: FSM state encoding, RAM geometry and the
// accumulator CPU opcode set (instruction word = {opcode[2:0], address[12:0]}).
package cpu_seq_pkg;

  localparam int unsigned AddrW = 13;
  localparam int unsigned DataW = 16;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StRun,
    StHalted,
    StTimeout
  } seq_state_e;

  typedef enum logic [2:0] {
    OpAdd  = 3'd0,
    OpNand = 3'd1,
    OpSrl  = 3'd2,
    OpGe   = 3'd3,
    OpSz   = 3'd4,
    OpCp2w = 3'd5,
    OpCpfw = 3'd6,
    OpJmp  = 3'd7
  } cpu_op_e;

  // Builds one instruction word from an opcode and its memory operand address.
  function automatic logic [DataW-1:0] make_instr(cpu_op_e op, logic [AddrW-1:0] addr);
    return {op, addr};
  endfunction

endpackage

// File: rtl/cpu_run_sequencer_if.sv
// Program-image loader stream: one word per handshake, last word flagged.
interface cpu_run_sequencer_if;
  import cpu_seq_pkg::*;

  logic             valid;
  logic             ready;
  logic [AddrW-1:0] addr;
  logic [DataW-1:0] data;
  logic             last;

  modport master (output valid, output addr, output data, output last, input ready);
  modport slave  (input valid, input addr, input data, input last, output ready);

endinterface

// File: rtl/pc_halt_detect.sv
// Halt detector: flags a CPU parked in a self-jump once its PC has stayed unchanged for
// HALT_WINDOW consecutive cycles. The stall counter only advances while run is high.
module pc_halt_detect
  import cpu_seq_pkg::*;
#(
  parameter int unsigned HALT_WINDOW = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [AddrW-1:0] pc,
  output logic             halt
);

  localparam int unsigned CntW = $clog2(HALT_WINDOW + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(HALT_WINDOW - 1);

  logic [AddrW-1:0] prev_pc_q;
  logic [CntW-1:0]  stall_q, stall_d;
  logic             same_pc;

  assign same_pc = (pc == prev_pc_q);

  // Count cycles whose PC equals the previous one; the HALT_WINDOW-th such cycle halts.
  always_comb begin
    stall_d = stall_q;
    halt    = 1'b0;
    if (!run || !same_pc) begin
      stall_d = '0;
    end else if (stall_q == LastCnt) begin
      halt = 1'b1;
    end else begin
      stall_d = stall_q + 1'b1;
    end
  end

  // PC history and stall counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_pc_q <= '0;
      stall_q   <= '0;
    end else begin
      prev_pc_q <= pc;
      stall_q   <= stall_d;
    end
  end

endmodule

// File: rtl/cpu_run_sequencer.sv
// Run sequencer for the accumulator CPU: loads a program image into RAM, releases the CPU,
// and stops on a self-jump halt or a cycle-budget timeout while counting RUN cycles.
// Optional feature macro: CPU_SEQ_DUMP_EN adds a RAM read-back port usable after a run.
module cpu_run_sequencer
  import cpu_seq_pkg::*;
#(
  parameter int unsigned HALT_WINDOW = 16,
  parameter int unsigned MAX_CYCLES  = 100000,
  parameter int unsigned CNT_W       = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  cpu_run_sequencer_if.slave   ld,
  output logic                 cpu_rst,
  input  logic [AddrW-1:0]     cpu_addr,
  input  logic                 cpu_wrEn,
  input  logic [DataW-1:0]     cpu_wdata,
  input  logic [AddrW-1:0]     cpu_PC,
  output logic [AddrW-1:0]     ram_addr,
  output logic                 ram_wrEn,
  output logic [DataW-1:0]     ram_wdata,
  input  logic [DataW-1:0]     ram_rdata,
  output logic                 busy,
  output logic                 done,
  output logic                 timeout,
  output logic [CNT_W-1:0]     cycles
`ifdef CPU_SEQ_DUMP_EN
  ,
  input  logic                 dump_req,
  input  logic [AddrW-1:0]     dump_addr,
  output logic                 dump_valid,
  output logic [DataW-1:0]     dump_data
`endif
);

  // cycles reaches MAX_CYCLES on the edge that leaves this value behind.
  localparam logic [CNT_W-1:0] CycLimit = CNT_W'(MAX_CYCLES - 1);

  seq_state_e       state_q, state_d;
  logic [CNT_W-1:0] cycles_q, cycles_d;
  logic             done_q, timeout_q;
  logic             halt;
  logic             in_run;

  assign in_run = (state_q == StRun);

  pc_halt_detect #(
    .HALT_WINDOW(HALT_WINDOW)
  ) u_pc_halt_detect (
    .clk (clk),
    .rst (rst),
    .run (in_run),
    .pc  (cpu_PC),
    .halt(halt)
  );

  // Next-state and cycle-counter logic; halt takes priority over timeout.
  always_comb begin
    state_d  = state_q;
    cycles_d = cycles_q;
    unique case (state_q)
      StIdle, StHalted, StTimeout: begin
        if (start) begin
          state_d  = StLoad;
          cycles_d = '0;
        end
      end
      StLoad: begin
        if (ld.valid && ld.last) state_d = StRun;
      end
      StRun: begin
        if (cycles_q != '1) cycles_d = cycles_q + 1'b1;
        if (halt) begin
          state_d = StHalted;
        end else if (cycles_q >= CycLimit) begin
          state_d = StTimeout;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State, counter and registered status flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      cycles_q  <= '0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cycles_q  <= cycles_d;
      done_q    <= (state_d == StHalted);
      timeout_q <= (state_d == StTimeout);
    end
  end

  assign ld.ready = (state_q == StLoad);
  assign cpu_rst  = !in_run;
  assign busy     = (state_q == StLoad) || in_run;
  assign done     = done_q;
  assign timeout  = timeout_q;
  assign cycles   = cycles_q;

`ifdef CPU_SEQ_DUMP_EN
  logic dump_ok;
  logic dump_valid_q;

  assign dump_ok = (state_q == StHalted) || (state_q == StTimeout);

  // Read-back data is the RAM output one cycle after the dump address was presented.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dump_valid_q <= 1'b0;
    end else begin
      dump_valid_q <= dump_req && dump_ok;
    end
  end

  assign dump_valid = dump_valid_q;
  assign dump_data  = ram_rdata;
`else
  // Read data only feeds the CPU directly when no dump port exists.
  logic unused_rdata;
  assign unused_rdata = ^ram_rdata;
`endif

  // RAM port mux selected by the registered state; CPU path is purely combinational.
  always_comb begin
    ram_addr  = '0;
    ram_wdata = '0;
    ram_wrEn  = 1'b0;
    unique case (state_q)
      StLoad: begin
        ram_addr  = ld.addr;
        ram_wdata = ld.data;
        ram_wrEn  = ld.valid;
      end
      StRun: begin
        ram_addr  = cpu_addr;
        ram_wdata = cpu_wdata;
        ram_wrEn  = cpu_wrEn;
      end
      default: begin
`ifdef CPU_SEQ_DUMP_EN
        if (dump_req && dump_ok) ram_addr = dump_addr;
`endif
      end
    endcase
  end

endmodule
